// File: rtl/matmul_pkg.sv
// Shared constants and width helpers for the matrix-multiply datapath.
package matmul_pkg;

  localparam int PROD_W = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Sum of k values of dw bits never exceeds dw + clog2(k) bits.
  function automatic int acc_width(input int dw, input int k);
    return dw + clog2(k);
  endfunction

endpackage

// File: rtl/dot_product_accumulator_axis_out_reg.sv
// One-entry valid/ready holding register; a load may coincide with a drain.
module axis_out_reg
  import matmul_pkg::*;
#(
  parameter int DATA_W   = 66,
  parameter int IDX_W    = 4,
  parameter int LAST_IDX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [IDX_W-1:0]  idx,
  output logic              last
);

  logic full;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
      idx  <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
      idx  <= load_idx;
    end else if (full && ready) begin
      full <= 1'b0;
    end
  end

  assign valid = full;
  assign last  = full && (idx == IDX_W'(LAST_IDX));

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums K consecutive products into one dot-product element per output.
module dot_product_accumulator
  import matmul_pkg::*;
#(
  parameter  int DATA_W = PROD_W,
  parameter  int K      = 4,
  parameter  int N_OUT  = 16,
  localparam int ACC_W  = acc_width(DATA_W, K),
  localparam int IDX_W  = (clog2(N_OUT) > 0) ? clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_prod_tdata,
  input  logic              s_prod_tvalid,
  output logic              s_prod_tready,
  output logic [ACC_W-1:0]  m_sum_tdata,
  output logic              m_sum_tvalid,
  input  logic              m_sum_tready,
  output logic [IDX_W-1:0]  m_sum_index,
  output logic              m_sum_tlast
);

  localparam int CNT_W = (clog2(K) > 0) ? clog2(K) : 1;

  typedef enum logic [1:0] {
    FIRST,
    ACCUM,
    FINAL
  } phase_t;

  phase_t           phase;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] cnt_idx, idx_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_W-1:0] ext, sum;
  logic             fire, load;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      cnt_idx <= '0;
    end else begin
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      cnt_idx <= idx_nxt;
    end
  end

  always_comb begin
    phase   = FIRST;
    cnt_nxt = cnt;
    acc_nxt = acc;
    idx_nxt = cnt_idx;
    load    = 1'b0;
    // FINAL is tested first so K=1 treats cnt=0 as the last term.
    if (cnt == CNT_W'(K - 1)) phase = FINAL;
    else if (cnt != '0)       phase = ACCUM;
    ext  = ACC_W'(s_prod_tdata);
    sum  = (cnt == '0) ? ext : acc + ext;
    s_prod_tready = (phase != FINAL) || !m_sum_tvalid
                    || m_sum_tready;
    fire = s_prod_tvalid && s_prod_tready;
    if (fire) begin
      unique case (phase)
        FIRST: begin
          acc_nxt = ext;
          cnt_nxt = CNT_W'(1);
        end
        ACCUM: begin
          acc_nxt = sum;
          cnt_nxt = cnt + CNT_W'(1);
        end
        FINAL: begin
          load    = 1'b1;
          cnt_nxt = '0;
          if (cnt_idx == IDX_W'(N_OUT - 1)) idx_nxt = '0;
          else idx_nxt = cnt_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  axis_out_reg #(
    .DATA_W   (ACC_W),
    .IDX_W    (IDX_W),
    .LAST_IDX (N_OUT - 1)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (sum),
    .load_idx  (cnt_idx),
    .ready     (m_sum_tready),
    .valid     (m_sum_tvalid),
    .data      (m_sum_tdata),
    .idx       (m_sum_index),
    .last      (m_sum_tlast)
  );

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator (K=4 and K=1 instances).
module tb_dot_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [65:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  m_idx;
  logic        m_last;

  logic [63:0] k_s_data = '0;
  logic        k_s_valid = 1'b0;
  logic        k_s_ready;
  logic [63:0] k_m_data;
  logic        k_m_valid;
  logic        k_m_ready = 1'b1;
  logic [3:0]  k_m_idx;
  logic        k_m_last;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dot_product_accumulator #(.DATA_W(64), .K(4), .N_OUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_prod_tdata  (s_data),
    .s_prod_tvalid (s_valid),
    .s_prod_tready (s_ready),
    .m_sum_tdata   (m_data),
    .m_sum_tvalid  (m_valid),
    .m_sum_tready  (m_ready),
    .m_sum_index   (m_idx),
    .m_sum_tlast   (m_last)
  );

  dot_product_accumulator #(.DATA_W(64), .K(1), .N_OUT(16)) dut_k1 (
    .clk           (clk),
    .rst           (rst),
    .s_prod_tdata  (k_s_data),
    .s_prod_tvalid (k_s_valid),
    .s_prod_tready (k_s_ready),
    .m_sum_tdata   (k_m_data),
    .m_sum_tvalid  (k_m_valid),
    .m_sum_tready  (k_m_ready),
    .m_sum_index   (k_m_idx),
    .m_sum_tlast   (k_m_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got %0b want 0", m_valid);
    end
    tests++;
    if (m_data !== 66'd0 || m_idx !== 4'd0 || m_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_out got %0h/%0d/%0b want 0/0/0",
               m_data, m_idx, m_last);
    end
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_sready got %0b want 1", s_ready);
    end
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_data = 64'(i);
      s_valid = 1'b1;
      #1;
      tests++;
      if (m_valid !== 1'b0) begin
        fails++;
        $display("FAIL basic_early_valid term %0d got %0b want 0",
                 i, m_valid);
      end
      step();
    end
    s_valid = 1'b0;
    tests++;
    if (m_valid !== 1'b1 || m_data !== 66'd10) begin
      fails++;
      $display("FAIL basic_sum got v=%0b d=%0d want v=1 d=10",
               m_valid, m_data);
    end
    tests++;
    if (m_idx !== 4'd0 || m_last !== 1'b0) begin
      fails++;
      $display("FAIL basic_idx got %0d/%0b want 0/0", m_idx, m_last);
    end
    step();
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_drain got %0b want 0", m_valid);
    end
  endtask

  task automatic test_max();
    m_ready = 1'b1;
    s_data = '1;
    s_valid = 1'b1;
    repeat (4) step();
    s_valid = 1'b0;
    tests++;
    if (m_valid !== 1'b1 || m_data !== 66'h3_FFFF_FFFF_FFFF_FFFC) begin
      fails++;
      $display("FAIL max_sum got v=%0b d=%0h want v=1 d=3fffffffffffffffc",
               m_valid, m_data);
    end
    tests++;
    if (m_idx !== 4'd1) begin
      fails++;
      $display("FAIL max_idx got %0d want 1", m_idx);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [63:0] vec [3];
    vec[0] = 64'd5;
    vec[1] = 64'd6;
    vec[2] = 64'd7;
    do_reset();
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      s_data = 64'(i);
      s_valid = 1'b1;
      step();
    end
    for (int j = 0; j < 3; j++) begin
      s_data = vec[j];
      #1;
      tests++;
      if (s_ready !== 1'b1) begin
        fails++;
        $display("FAIL stall_accept term %0d got %0b want 1", j, s_ready);
      end
      step();
    end
    s_data = 64'd8;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++;
      if (s_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_final cyc %0d got %0b want 0", c, s_ready);
      end
      tests++;
      if (m_valid !== 1'b1 || m_data !== 66'd10 || m_idx !== 4'd0) begin
        fails++;
        $display("FAIL stall_hold got v=%0b d=%0d i=%0d want 1/10/0",
                 m_valid, m_data, m_idx);
      end
      step();
    end
    m_ready = 1'b1;
    #1;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL release_sready got %0b want 1", s_ready);
    end
    step();
    tests++;
    if (m_valid !== 1'b1 || m_data !== 66'd26 || m_idx !== 4'd1) begin
      fails++;
      $display("FAIL b2b_second got v=%0b d=%0d i=%0d want 1/26/1",
               m_valid, m_data, m_idx);
    end
    s_data = 64'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) begin
        tests++;
        if (m_valid !== 1'b0) begin
          fails++;
          $display("FAIL b2b_gap term %0d got %0b want 0", i, m_valid);
        end
      end
    end
    s_valid = 1'b0;
    tests++;
    if (m_valid !== 1'b1 || m_data !== 66'd4 || m_idx !== 4'd2) begin
      fails++;
      $display("FAIL b2b_third got v=%0b d=%0d i=%0d want 1/4/2",
               m_valid, m_data, m_idx);
    end
    step();
  endtask

  task automatic test_index_wrap();
    int exp_idx;
    int seen;
    int last_seen;
    exp_idx = 0;
    seen = 0;
    last_seen = -1;
    do_reset();
    m_ready = 1'b1;
    s_data = 64'd1;
    s_valid = 1'b1;
    for (int c = 0; c < 68; c++) begin
      step();
      if (m_valid === 1'b1) begin
        tests++;
        if (m_idx !== 4'(exp_idx) || m_data !== 66'd4 ||
            m_last !== (exp_idx == 15)) begin
          fails++;
          $display("FAIL wrap_elem %0d got i=%0d d=%0d l=%0b want i=%0d d=4 l=%0b",
                   seen, m_idx, m_data, m_last, exp_idx, exp_idx == 15);
        end
        last_seen = int'(m_idx);
        exp_idx = (exp_idx + 1) % 16;
        seen++;
      end
    end
    s_valid = 1'b0;
    tests++;
    if (seen != 17 || last_seen != 0) begin
      fails++;
      $display("FAIL wrap_count got n=%0d last=%0d want n=17 last=0",
               seen, last_seen);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data = 64'd5;
    step();
    s_data = 64'd6;
    step();
    s_valid = 1'b0;
    do_reset();
    s_valid = 1'b1;
    s_data = 64'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (m_valid !== 1'b0) begin
        fails++;
        $display("FAIL rmid_stray term %0d got v=%0b d=%0d want v=0",
                 i, m_valid, m_data);
      end
      step();
    end
    s_valid = 1'b0;
    tests++;
    if (m_valid !== 1'b1 || m_data !== 66'd4 || m_idx !== 4'd0) begin
      fails++;
      $display("FAIL rmid_sum got v=%0b d=%0d i=%0d want 1/4/0",
               m_valid, m_data, m_idx);
    end
    m_ready = 1'b0;
    step();
    do_reset();
    #1;
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL rmid_drop got %0b want 0", m_valid);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_k1();
    do_reset();
    k_m_ready = 1'b1;
    k_s_valid = 1'b1;
    k_s_data = 64'd7;
    #1;
    tests++;
    if (k_s_ready !== 1'b1) begin
      fails++;
      $display("FAIL k1_ready0 got %0b want 1", k_s_ready);
    end
    step();
    tests++;
    if (k_m_valid !== 1'b1 || k_m_data !== 64'd7 || k_m_idx !== 4'd0) begin
      fails++;
      $display("FAIL k1_first got v=%0b d=%0d i=%0d want 1/7/0",
               k_m_valid, k_m_data, k_m_idx);
    end
    k_s_data = 64'd9;
    #1;
    tests++;
    if (k_s_ready !== 1'b1) begin
      fails++;
      $display("FAIL k1_ready1 got %0b want 1", k_s_ready);
    end
    step();
    k_s_valid = 1'b0;
    tests++;
    if (k_m_valid !== 1'b1 || k_m_data !== 64'd9 || k_m_idx !== 4'd1) begin
      fails++;
      $display("FAIL k1_second got v=%0b d=%0d i=%0d want 1/9/1",
               k_m_valid, k_m_data, k_m_idx);
    end
    step();
    tests++;
    if (k_m_valid !== 1'b0) begin
      fails++;
      $display("FAIL k1_drain got %0b want 0", k_m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_index_wrap();
    test_reset_mid();
    test_k1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
